wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_LEN, default 64, is the register and datapath width.
REQ-002 Parameter CONTROL_LINE, default 2, is the width of the writeback control bundle.
REQ-003 Parameter INSTRUCTION_PART, default 5, is the register index width; the file holds 2**INSTRUCTION_PART registers.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 control_in  input  CONTROL_LINE  writeback control from the MEM/WB register: bit1 = RegWrite, bit0 = MemtoReg.
REQ-007 rd_data  input  DATA_LEN  memory load data from the MEM/WB register.
REQ-008 addr  input  DATA_LEN  ALU result from the MEM/WB register.
REQ-009 instruction_part  input  INSTRUCTION_PART  destination register index rd.
REQ-010 rs1_addr  input  INSTRUCTION_PART  read port 1 index.
REQ-011 rs2_addr  input  INSTRUCTION_PART  read port 2 index.
REQ-012 rs1_data  output  DATA_LEN  read port 1 data.
REQ-013 rs2_data  output  DATA_LEN  read port 2 data.
REQ-014 wb_data  output  DATA_LEN  selected writeback value.
REQ-015 wb_en  output  1  effective write enable this cycle.
REQ-016 retire_count  output  32  count of committed register writes.

Function
REQ-017 wb_data SHALL be combinational: rd_data when MemtoReg=1, else addr.
REQ-018 wb_en SHALL be combinational: RegWrite AND (instruction_part != 0) AND rst.
REQ-019 On a rising clk with wb_en=1, register[instruction_part] SHALL load wb_data; all other registers SHALL hold.
REQ-020 Register 0 SHALL never be written and SHALL always read as 0.
REQ-021 Read ports SHALL be combinational, with zero-cycle latency from rs*_addr.
REQ-022 Same-cycle bypass: when wb_en=1 and rs*_addr == instruction_part, rs*_data SHALL equal wb_data, not the stale stored value.
REQ-023 Both read ports SHALL bypass independently; rs1_addr == rs2_addr SHALL yield identical data on both ports.
REQ-024 When rs*_addr is 0, rs*_data SHALL be 0 regardless of bypass conditions.
REQ-025 retire_count SHALL increment by 1 on each rising clk where wb_en=1.
REQ-026 retire_count SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag or saturation.
REQ-027 When RegWrite=0, no state SHALL change; the MemtoReg value SHALL be ignored for state but still drive wb_data.
REQ-028 Back-to-back writes to the same rd on consecutive cycles SHALL leave the last value stored; each write increments retire_count.

Reset
REQ-029 While rst=0, all registers SHALL be 0 and retire_count SHALL be 0, asynchronously and independent of clk.
REQ-030 While rst=0, wb_en SHALL be 0, and rs1_data/rs2_data SHALL read 0 with no bypass.
REQ-031 A write whose clock edge coincides with rst=0 SHALL be dropped.
REQ-032 The first write SHALL be accepted on the first rising clk after rst deasserts.

Verification
REQ-033 Reset: assert rst=0 mid-run after writing x5=0xDEAD -> rs1_addr=5 reads 0 immediately, with no clk edge; retire_count=0.
REQ-034 ALU writeback: control_in=2'b10, addr=0x1234, rd_data=0x9999, instruction_part=7, one clk -> rs2_addr=7 reads 0x1234; retire_count=1.
REQ-035 Load writeback with bypass: control_in=2'b11, rd_data=0xCAFE, instruction_part=3, rs1_addr=3 before the edge -> rs1_data=0xCAFE in the same cycle; after the edge, x3 stores 0xCAFE.
REQ-036 x0 protection: control_in=2'b10, addr=0xFFFF, instruction_part=0 -> wb_en=0, rs1_addr=0 reads 0, retire_count unchanged.
REQ-037 No-write: control_in=2'b01, instruction_part=4 -> x4 unchanged, wb_data equals rd_data, retire_count unchanged.
REQ-038 Counter wrap: force 0xFFFFFFFF committed writes (or preload via a test hook), then one more write -> retire_count=0.

Source files
------------

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage and integer register file. Selects the
//               writeback value (load data or ALU result), commits it to
//               register rd, and serves two combinational read ports with
//               same-cycle bypass of the value being written. x0 is
//               hard-wired to zero. A 32-bit counter tracks committed writes.
//
// Ports       : clk              - clock, state updates on rising edge
//               rst              - asynchronous reset, active low
//               control_in       - [1] RegWrite, [0] MemtoReg
//               rd_data          - load data from MEM/WB
//               addr             - ALU result from MEM/WB
//               instruction_part - destination register index rd
//               rs1_addr/rs2_addr- read port indices
//               rs1_data/rs2_data- read port data (bypassed)
//               wb_data          - selected writeback value
//               wb_en            - effective write enable this cycle
//               retire_count     - committed register writes (wraps)
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_LEN         = 64,
    parameter int CONTROL_LINE     = 2,
    parameter int INSTRUCTION_PART = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CONTROL_LINE-1:0]     control_in,
    input  logic [DATA_LEN-1:0]         rd_data,
    input  logic [DATA_LEN-1:0]         addr,
    input  logic [INSTRUCTION_PART-1:0] instruction_part,
    input  logic [INSTRUCTION_PART-1:0] rs1_addr,
    input  logic [INSTRUCTION_PART-1:0] rs2_addr,
    output logic [DATA_LEN-1:0]         rs1_data,
    output logic [DATA_LEN-1:0]         rs2_data,
    output logic [DATA_LEN-1:0]         wb_data,
    output logic                        wb_en,
    output logic [31:0]                 retire_count
);

    localparam int c_NUM_REGS = 2 ** INSTRUCTION_PART;

    logic                w_reg_write;
    logic                w_mem_to_reg;
    logic [DATA_LEN-1:0] w_regs [c_NUM_REGS];
    logic [31:0]         r_retire_count;

    assign w_reg_write  = control_in[1];
    assign w_mem_to_reg = control_in[0];

    assign wb_data = w_mem_to_reg ? rd_data : addr;
    // rst is part of the enable so nothing is committed or bypassed while
    // the file is held in reset.
    assign wb_en   = w_reg_write && (instruction_part != '0) && rst;

    // One storage element per register; x0 is a constant so it can never
    // hold anything but zero.
    for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_live
            logic [DATA_LEN-1:0] r_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else if (wb_en && (instruction_part == INSTRUCTION_PART'(gi))) begin
                    r_q <= wb_data;
                end
            end

            assign w_regs[gi] = r_q;
        end
    end

    // Read ports: x0 and reset force zero; otherwise a matching in-flight
    // write takes priority over the stored (stale) value.
    always_comb begin
        rs1_data = w_regs[rs1_addr];
        if ((rs1_addr == '0) || !rst) begin
            rs1_data = '0;
        end else if (wb_en && (rs1_addr == instruction_part)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = w_regs[rs2_addr];
        if ((rs2_addr == '0) || !rst) begin
            rs2_data = '0;
        end else if (wb_en && (rs2_addr == instruction_part)) begin
            rs2_data = wb_data;
        end
    end

    // Free-running modulo-2^32 count of committed writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_count <= '0;
        end else if (wb_en) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. Expected values come
//               from a behavioural register-file model and are queued on a
//               scoreboard before the matching DUT output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam int c_DW = 64;
    localparam int c_IW = 5;

    logic            clk;
    logic            rst;
    logic [1:0]      control_in;
    logic [c_DW-1:0] rd_data;
    logic [c_DW-1:0] addr;
    logic [c_IW-1:0] instruction_part;
    logic [c_IW-1:0] rs1_addr;
    logic [c_IW-1:0] rs2_addr;
    logic [c_DW-1:0] rs1_data;
    logic [c_DW-1:0] rs2_data;
    logic [c_DW-1:0] wb_data;
    logic            wb_en;
    logic [31:0]     retire_count;

    wb_regfile #(
        .DATA_LEN         (c_DW),
        .CONTROL_LINE     (2),
        .INSTRUCTION_PART (c_IW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .control_in       (control_in),
        .rd_data          (rd_data),
        .addr             (addr),
        .instruction_part (instruction_part),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .wb_data          (wb_data),
        .wb_en            (wb_en),
        .retire_count     (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [c_DW-1:0] m_regs [32];
    logic [31:0]     m_count;

    function automatic logic m_wb_en();
        return control_in[1] && (instruction_part != '0) && rst;
    endfunction

    function automatic logic [c_DW-1:0] m_wb_data();
        return control_in[0] ? rd_data : addr;
    endfunction

    function automatic logic [c_DW-1:0] m_read(input logic [c_IW-1:0] a);
        if (a == '0 || !rst) return '0;
        if (m_wb_en() && a == instruction_part) return m_wb_data();
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_count = '0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string           tag;
        logic [c_DW-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [c_DW-1:0] obs,
                         input logic [c_DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [c_DW-1:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [c_DW-1:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    // Queue model expectations for every output, then compare in order.
    task automatic check_all(input string tag);
        push_exp({tag, "_wb_data"}, m_wb_data());
        push_exp({tag, "_wb_en"}, {63'd0, m_wb_en()});
        push_exp({tag, "_rs1"}, m_read(rs1_addr));
        push_exp({tag, "_rs2"}, m_read(rs2_addr));
        push_exp({tag, "_count"}, {32'd0, m_count});
        #1;
        pop_check(wb_data);
        pop_check({63'd0, wb_en});
        pop_check(rs1_data);
        pop_check(rs2_data);
        pop_check({32'd0, retire_count});
    endtask

    task automatic drive(input logic [1:0] ctrl, input logic [c_DW-1:0] rdd,
                         input logic [c_DW-1:0] ad, input logic [c_IW-1:0] rd,
                         input logic [c_IW-1:0] r1, input logic [c_IW-1:0] r2);
        control_in       = ctrl;
        rd_data          = rdd;
        addr             = ad;
        instruction_part = rd;
        rs1_addr         = r1;
        rs2_addr         = r2;
    endtask

    // Advance one clock, committing into the model what the DUT should commit.
    task automatic step();
        logic            en;
        logic [c_DW-1:0] d;
        logic [c_IW-1:0] rd;
        en = m_wb_en();
        d  = m_wb_data();
        rd = instruction_part;
        @(posedge clk);
        if (en) begin
            m_regs[rd] = d;
            m_count    = m_count + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        m_reset();
        rst = 1'b0;
        drive(2'b10, 64'h9999, 64'h55, 5'd7, 5'd7, 5'd7);
        @(negedge clk);
        check_all("in_reset");
        step();                                   // edge while in reset: dropped
        check_all("reset_edge_dropped");

        // ALU writeback accepted on first edge after reset release
        rst = 1'b1;
        drive(2'b10, 64'h9999, 64'h1234, 5'd7, 5'd0, 5'd7);
        check_all("alu_pre");
        step();
        drive(2'b00, 64'h0, 64'h0, 5'd7, 5'd0, 5'd7);
        check_all("alu_post");

        // Load writeback with same-cycle bypass on both ports
        drive(2'b11, 64'hCAFE, 64'h1111, 5'd3, 5'd3, 5'd3);
        check_all("load_bypass");
        step();
        drive(2'b00, 64'h0, 64'h0, 5'd3, 5'd3, 5'd7);
        check_all("load_stored");

        // x0 protection
        drive(2'b10, 64'h0, 64'hFFFF, 5'd0, 5'd0, 5'd0);
        check_all("x0_pre");
        step();
        check_all("x0_post");

        // RegWrite=0: no state change, wb_data still follows MemtoReg
        drive(2'b01, 64'hBEEF, 64'h7, 5'd4, 5'd4, 5'd4);
        check_all("nowrite_pre");
        step();
        check_all("nowrite_post");

        // Back-to-back writes to one register
        drive(2'b10, 64'h0, 64'hA, 5'd9, 5'd9, 5'd0);
        check_all("b2b_first");
        step();
        drive(2'b10, 64'h0, 64'hB, 5'd9, 5'd9, 5'd9);
        check_all("b2b_second");
        step();
        drive(2'b00, 64'h0, 64'h0, 5'd9, 5'd9, 5'd9);
        check_all("b2b_final");

        // Random traffic over a small index range to force collisions
        for (int i = 0; i < 40; i++) begin
            drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
            check_all("rand");
            step();
        end
        drive(2'b00, 64'h0, 64'h0, 5'd0, 5'd1, 5'd2);
        check_all("rand_end");

        // Asynchronous reset mid-cycle after writing x5
        drive(2'b10, 64'h0, 64'hDEAD, 5'd5, 5'd5, 5'd5);
        step();
        drive(2'b00, 64'h0, 64'h0, 5'd5, 5'd5, 5'd5);
        check_all("x5_written");
        #2;
        rst = 1'b0;
        m_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b1;
        check_all("after_reset");

        // Counter wrap: preload the counter one short of wrapping
        dut.r_retire_count = 32'hFFFF_FFFF;
        m_count            = 32'hFFFF_FFFF;
        drive(2'b10, 64'h0, 64'h42, 5'd6, 5'd6, 5'd0);
        check_all("wrap_pre");
        step();
        drive(2'b00, 64'h0, 64'h0, 5'd6, 5'd6, 5'd0);
        check_all("wrap_post");

        if (sb.size() != 0) check("scoreboard_leftover", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
